// File: rtl/eth_frame_loop_pkg.sv
// Shared types and helpers for the Ethernet frame loopback buffer.
package eth_frame_loop_pkg;

  localparam int BYTE_CNT_W = 16;
  localparam int ACC_W      = BYTE_CNT_W + 1;

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_IDLE,
    ST_FRAME,
    ST_DISCARD
  } wr_state_e;

  // Keep width is at most 8; narrower keeps are zero-extended by the caller.
  function automatic logic [3:0] keep_popcount(input logic [7:0] keep);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, keep[i]};
    return n;
  endfunction

endpackage

// File: rtl/eth_frame_loop_ram.sv
// Simple dual-port RAM: synchronous write, registered read (read data holds when re_i is low).
module eth_frame_loop_ram #(
  parameter int C_WIDTH = 8,
  parameter int C_AW    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [C_AW-1:0]    waddr_i,
  input  logic [C_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic [C_AW-1:0]    raddr_i,
  output logic [C_WIDTH-1:0] rdata_o
);

  logic [C_WIDTH-1:0] mem_q [2**C_AW];
  logic [C_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/eth_frame_loop_buffer.sv
// Store-and-forward loopback buffer: whole frames only, overflowing frames dropped entirely.
// Output streams: a beat transfers on the rising edge where tvalid & tready; tvalid/tdata hold until then.
module eth_frame_loop_buffer
  import eth_frame_loop_pkg::*;
#(
  parameter int C_DATA_WIDTH = 8,
  parameter int C_USER_WIDTH = 48,
  parameter int C_DEPTH      = 2048,
  parameter int C_CTL_DEPTH  = 64,
  parameter int C_DROP_BAD   = 0,
  localparam int C_KEEP_WIDTH = C_DATA_WIDTH / 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [C_DATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [C_KEEP_WIDTH-1:0]        s_axis_tkeep,
  input  logic [C_USER_WIDTH-1:0]        s_axis_tuser,
  input  logic                           s_axis_tlast,
  input  logic                           s_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]        m_axis_frame_tdata,
  output logic [C_KEEP_WIDTH-1:0]        m_axis_frame_tkeep,
  output logic                           m_axis_frame_tlast,
  output logic                           m_axis_frame_tvalid,
  input  logic                           m_axis_frame_tready,
  output logic [C_USER_WIDTH+15:0]       m_axis_ctl_tdata,
  output logic                           m_axis_ctl_tvalid,
  input  logic                           m_axis_ctl_tready,
  output logic [31:0]                    drop_count,
  output logic [31:0]                    bad_count,
  output logic                           overflow
);

  localparam int AW  = $clog2(C_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CAW = $clog2(C_CTL_DEPTH);
  localparam int CPW = CAW + 1;
  localparam int MW  = C_KEEP_WIDTH + 1 + C_DATA_WIDTH;
  localparam int CW  = C_USER_WIDTH + BYTE_CNT_W;

  wr_state_e        state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, rd_ptr_q;
  logic [CPW-1:0]   ctl_wr_q, ctl_rd_q, ctl_ret_q;
  logic [ACC_W-1:0] byte_acc_q, byte_acc_d, acc_base, acc_new;
  logic [ACC_W:0]   acc_sum;
  logic [BYTE_CNT_W-1:0] byte_count;
  logic [31:0]      drop_cnt_q, bad_cnt_q;
  logic             overflow_q;
  logic             buf_full, ctl_full;
  logic             beat_we, acc_start, space_drop, rewind_drop;
  logic             frame_end, bad_end, good_end;

  // A ctl slot only needs checking at a frame's first beat: one frame is in flight at a time
  // and reads only ever free slots, so the end-of-frame push always has room.
  assign buf_full = (wr_ptr_q - rd_ptr_q) == PW'(C_DEPTH);
  assign ctl_full = (ctl_wr_q - ctl_ret_q) == CPW'(C_CTL_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_SYNC;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_SYNC:    if (!s_axis_tvalid || s_axis_tlast) state_d = ST_IDLE;
      ST_IDLE:    if (s_axis_tvalid && !s_axis_tlast)
                    state_d = (ctl_full || buf_full) ? ST_DISCARD : ST_FRAME;
      ST_FRAME:   if (s_axis_tvalid) begin
                    if (s_axis_tlast)  state_d = ST_IDLE;
                    else if (buf_full) state_d = ST_DISCARD;
                  end
      ST_DISCARD: if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      default:    state_d = ST_SYNC;
    endcase
  end

  always_comb begin
    beat_we     = 1'b0;
    acc_start   = 1'b0;
    space_drop  = 1'b0;
    rewind_drop = 1'b0;
    unique case (state_q)
      ST_IDLE: if (s_axis_tvalid) begin
        if (ctl_full || buf_full) space_drop = 1'b1;
        else begin
          beat_we   = 1'b1;
          acc_start = 1'b1;
        end
      end
      ST_FRAME: if (s_axis_tvalid) begin
        if (buf_full) begin
          space_drop  = 1'b1;
          rewind_drop = 1'b1;
        end else beat_we = 1'b1;
      end
      default: ;
    endcase
  end

  assign frame_end = beat_we & s_axis_tlast;
  assign bad_end   = frame_end & (C_DROP_BAD != 0) & s_axis_tuser[0];
  assign good_end  = frame_end & ~bad_end;

  always_comb begin
    acc_base   = acc_start ? '0 : byte_acc_q;
    acc_sum    = {1'b0, acc_base} + (ACC_W + 1)'(keep_popcount(8'(s_axis_tkeep)));
    acc_new    = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    byte_count = acc_new[ACC_W-1] ? '1 : acc_new[BYTE_CNT_W-1:0];
    byte_acc_d = beat_we ? acc_new : byte_acc_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    if (rewind_drop || bad_end) wr_ptr_d = wr_commit_q;
    else if (beat_we) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (frame_end) wr_commit_d = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      byte_acc_q  <= '0;
      ctl_wr_q    <= '0;
      drop_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      byte_acc_q  <= byte_acc_d;
      overflow_q  <= space_drop;
      if (good_end) ctl_wr_q <= ctl_wr_q + 1'b1;
      if (space_drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (bad_end && bad_cnt_q != '1)     bad_cnt_q  <= bad_cnt_q + 1'b1;
    end
  end

  // Frame read path: RAM read in flight (pend), output register and a skid register.
  // Reads are issued only while the result is guaranteed a free register.
  logic          pend_q, out_v_q, out_v_d, skid_v_q, skid_v_d, frm_pop, rd_issue;
  logic [MW-1:0] ram_rdata, out_q, out_d, skid_q, skid_d;
  logic [1:0]    occ_after;

  assign frm_pop   = out_v_q & m_axis_frame_tready;
  assign occ_after = 2'(out_v_q) + 2'(skid_v_q) + 2'(pend_q) - 2'(frm_pop);
  assign rd_issue  = (rd_ptr_q != wr_commit_q) && (occ_after < 2'd2);

  always_comb begin
    out_v_d  = out_v_q;
    out_d    = out_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (!out_v_q || frm_pop) begin
      if (skid_v_q) begin
        out_v_d  = 1'b1;
        out_d    = skid_q;
        skid_v_d = pend_q;
        skid_d   = ram_rdata;
      end else if (pend_q) begin
        out_v_d = 1'b1;
        out_d   = ram_rdata;
      end else out_v_d = 1'b0;
    end else if (pend_q) begin
      skid_v_d = 1'b1;
      skid_d   = ram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      pend_q   <= 1'b0;
      out_v_q  <= 1'b0;
      out_q    <= '0;
      skid_v_q <= 1'b0;
      skid_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(rd_issue);
      pend_q   <= rd_issue;
      out_v_q  <= out_v_d;
      out_q    <= out_d;
      skid_v_q <= skid_v_d;
      skid_q   <= skid_d;
    end
  end

  eth_frame_loop_ram #(.C_WIDTH(MW), .C_AW(AW)) u_frame_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (beat_we),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i ({s_axis_tkeep, s_axis_tlast, s_axis_tdata}),
    .re_i    (rd_issue),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Ctl queue: the RAM read register is the output register; ret pointer frees on handshake.
  logic ctl_v_q, ctl_re;

  assign ctl_re = (ctl_rd_q != ctl_wr_q) && (!ctl_v_q || m_axis_ctl_tready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctl_v_q   <= 1'b0;
      ctl_rd_q  <= '0;
      ctl_ret_q <= '0;
    end else begin
      ctl_v_q   <= ctl_re | (ctl_v_q & ~m_axis_ctl_tready);
      ctl_rd_q  <= ctl_rd_q + CPW'(ctl_re);
      ctl_ret_q <= ctl_ret_q + CPW'(ctl_v_q & m_axis_ctl_tready);
    end
  end

  eth_frame_loop_ram #(.C_WIDTH(CW), .C_AW(CAW)) u_ctl_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (good_end),
    .waddr_i (ctl_wr_q[CAW-1:0]),
    .wdata_i ({s_axis_tuser, byte_count}),
    .re_i    (ctl_re),
    .raddr_i (ctl_rd_q[CAW-1:0]),
    .rdata_o (m_axis_ctl_tdata)
  );

  assign {m_axis_frame_tkeep, m_axis_frame_tlast, m_axis_frame_tdata} = out_q;
  assign m_axis_frame_tvalid = out_v_q;
  assign m_axis_ctl_tvalid   = ctl_v_q;
  assign drop_count          = drop_cnt_q;
  assign bad_count           = bad_cnt_q;
  assign overflow            = overflow_q;

endmodule
